// File: rtl/alu_pkg.sv
// Shared ALU definitions: FSM state encoding and default datapath width.
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_adder_if.sv
// Operand/result handshake bundle for the bit-serial adder.
// The master issues operands and consumes results; the slave is the adder.
interface serial_adder_if
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             co;
  logic             ovf;

  modport master (
    output in_valid, a, b, ci, out_ready,
    input  in_ready, out_valid, sum, co, ovf
  );

  modport slave (
    input  in_valid, a, b, ci, out_ready,
    output in_ready, out_valid, sum, co, ovf
  );

endinterface

// File: rtl/full_adder.sv
// Single-bit full adder cell; purely combinational.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: operands are consumed LSB-first through one full-adder
// cell, one bit per cycle, with the carry held in a flop between cycles.
// Result (sum, carry-out, signed overflow) is registered and held until the
// next operation completes.
module serial_adder
  import alu_pkg::*;
#(
  parameter  int WIDTH = ALU_WIDTH,
  localparam int CW    = $clog2(WIDTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  serial_adder_if.slave   bus
);

  // Bit index of the MSB and the one below it, sized to the counter.
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_MSB  = CW'(WIDTH - 2);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             c_msb_q, c_msb_d;
  logic             co_q, co_d;
  logic             ovf_q, ovf_d;

  logic             fa_s;
  logic             fa_co;

  full_adder u_fa (
    .a  (a_sh_q[0]),
    .b  (b_sh_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  // Handshake flags decode from the state register alone.
  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.sum       = sum_q;
  assign bus.co        = co_q;
  assign bus.ovf       = ovf_q;

  // Next-state and datapath update for the load / shift / hand-off sequence.
  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    sum_d    = sum_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    c_msb_d  = c_msb_q;
    co_d     = co_q;
    ovf_d    = ovf_q;
    case (state_q)
      ST_IDLE: begin
        // in_ready is high in IDLE, so in_valid alone completes the handshake.
        if (bus.in_valid) begin
          a_sh_d  = bus.a;
          b_sh_d  = bus.b;
          carry_d = bus.ci;
          cnt_d   = {CW{1'b0}};
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        sum_sh_d = {fa_s, sum_sh_q[WIDTH-1:1]};
        a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
        carry_d  = fa_co;
        cnt_d    = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        // Carry out of bit WIDTH-2 is the carry into the MSB.
        if (cnt_q == CNT_MSB) begin
          c_msb_d = fa_co;
        end else begin
          c_msb_d = c_msb_q;
        end
        if (cnt_q == CNT_LAST) begin
          sum_d   = {fa_s, sum_sh_q[WIDTH-1:1]};
          co_d    = fa_co;
          ovf_d   = c_msb_q ^ fa_co;
          state_d = ST_DONE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        // Unused encoding recovers to IDLE.
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; async reset discards any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      a_sh_q   <= {WIDTH{1'b0}};
      b_sh_q   <= {WIDTH{1'b0}};
      sum_sh_q <= {WIDTH{1'b0}};
      sum_q    <= {WIDTH{1'b0}};
      cnt_q    <= {CW{1'b0}};
      carry_q  <= 1'b0;
      c_msb_q  <= 1'b0;
      co_q     <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      sum_q    <= sum_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      c_msb_q  <= c_msb_d;
      co_q     <= co_d;
      ovf_q    <= ovf_d;
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH=8: directed corner cases,
// randomized operands against an arithmetic reference, handshake behaviour
// and asynchronous reset mid-operation.
module tb_serial_adder;

  localparam int W = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int checks   = 0;
  int failures = 0;

  // Free-running 10-time-unit clock.
  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(W)) bus ();

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Reference: returns {ovf, co, sum} from plain integer arithmetic.
  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic c);
    logic [W:0] t;
    logic       v;
    t = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    v = (x[W-1] == y[W-1]) && (t[W-1] != x[W-1]);
    return {v, t};
  endfunction

  // Present one operand pair and hold it until accepted, then drop in_valid.
  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tci);
    int n;
    n = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.a        = ta;
    bus.b        = tb;
    bus.ci       = tci;
    while (bus.in_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 100) begin
      failures++;
      $display("FAIL send_accept: in_ready never rose within %0d cycles", n);
    end
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // Wait (bounded) for out_valid, sampling on falling edges.
  task automatic wait_done();
    int n;
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 100) begin
      failures++;
      $display("FAIL wait_done: out_valid never rose within %0d cycles", n);
    end
  endtask

  // Consume the current result with a one-cycle out_ready pulse.
  task automatic take();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (bus.sum !== 8'h00 || bus.co !== 1'b0 || bus.ovf !== 1'b0) begin
      failures++;
      $display("FAIL reset_result: got sum=%h co=%b ovf=%b want 00 0 0", bus.sum, bus.co, bus.ovf);
    end
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_flags: got out_valid=%b in_ready=%b want 0 1", bus.out_valid, bus.in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_latency();
    send(8'h0F, 8'h01, 1'b0);
    repeat (W - 1) @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL latency_early: out_valid=%b at %0d cycles want 0", bus.out_valid, W - 1);
    end
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b1) begin
      failures++;
      $display("FAIL latency_exact: out_valid=%b at %0d cycles want 1", bus.out_valid, W);
    end
    checks++;
    if (bus.sum !== 8'h10 || bus.co !== 1'b0 || bus.ovf !== 1'b0) begin
      failures++;
      $display("FAIL latency_result: got sum=%h co=%b ovf=%b want 10 0 0", bus.sum, bus.co, bus.ovf);
    end
    take();
  endtask

  task automatic test_corners();
    logic [W-1:0] va [4] = '{8'hFF, 8'hFF, 8'h7F, 8'h80};
    logic [W-1:0] vb [4] = '{8'h01, 8'hFF, 8'h01, 8'h80};
    logic         vc [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [W-1:0] es [4] = '{8'h00, 8'hFF, 8'h80, 8'h00};
    logic         ec [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic         eo [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      send(va[i], vb[i], vc[i]);
      wait_done();
      checks++;
      if (bus.sum !== es[i] || bus.co !== ec[i] || bus.ovf !== eo[i]) begin
        failures++;
        $display("FAIL corner_%0d: %h+%h+%b got sum=%h co=%b ovf=%b want %h %b %b",
                 i, va[i], vb[i], vc[i], bus.sum, bus.co, bus.ovf, es[i], ec[i], eo[i]);
      end
      take();
    end
  endtask

  task automatic test_random();
    logic [W-1:0] ra, rb;
    logic         rc;
    logic [W+1:0] exp;
    for (int i = 0; i < 25; i++) begin
      ra  = W'($urandom);
      rb  = W'($urandom);
      rc  = 1'($urandom);
      exp = model(ra, rb, rc);
      send(ra, rb, rc);
      wait_done();
      checks++;
      if ({bus.ovf, bus.co, bus.sum} !== exp) begin
        failures++;
        $display("FAIL random_%0d: %h+%h+%b got ovf/co/sum=%b/%b/%h want %b/%b/%h",
                 i, ra, rb, rc, bus.ovf, bus.co, bus.sum, exp[W+1], exp[W], exp[W-1:0]);
      end
      take();
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] ra, rb;
    logic [W+1:0] exp;
    ra  = W'($urandom);
    rb  = W'($urandom);
    exp = model(ra, rb, 1'b1);
    send(ra, rb, 1'b1);
    wait_done();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
          {bus.ovf, bus.co, bus.sum} !== exp) begin
        failures++;
        $display("FAIL hold_%0d: got out_valid=%b in_ready=%b ovf/co/sum=%b/%b/%h want 1 0 %b/%b/%h",
                 i, bus.out_valid, bus.in_ready, bus.ovf, bus.co, bus.sum,
                 exp[W+1], exp[W], exp[W-1:0]);
      end
    end
    take();
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || {bus.ovf, bus.co, bus.sum} !== exp) begin
      failures++;
      $display("FAIL release: got in_ready=%b out_valid=%b sum=%h want 1 0 %h",
               bus.in_ready, bus.out_valid, bus.sum, exp[W-1:0]);
    end
  endtask

  task automatic test_busy_ignore();
    send(8'h01, 8'h02, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.a        = 8'h55;
    bus.b        = 8'h00;
    bus.ci       = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL run_in_ready: got %b want 0", bus.in_ready);
    end
    wait_done();
    checks++;
    if (bus.sum !== 8'h03 || bus.co !== 1'b0) begin
      failures++;
      $display("FAIL busy_result: got sum=%h co=%b want 03 0", bus.sum, bus.co);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL idle_in_ready: got %b want 1", bus.in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_done();
    checks++;
    if (bus.sum !== 8'h55 || bus.co !== 1'b0) begin
      failures++;
      $display("FAIL late_accept: got sum=%h co=%b want 55 0", bus.sum, bus.co);
    end
    take();
  endtask

  task automatic test_async_reset();
    send(8'hAA, 8'h11, 1'b1);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.sum !== 8'h00 || bus.co !== 1'b0 || bus.ovf !== 1'b0 ||
        bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL async_reset: got sum=%h co=%b ovf=%b out_valid=%b in_ready=%b want 00 0 0 0 1",
               bus.sum, bus.co, bus.ovf, bus.out_valid, bus.in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    send(8'h3C, 8'h3C, 1'b0);
    wait_done();
    checks++;
    if (bus.sum !== 8'h78 || bus.co !== 1'b0 || bus.ovf !== 1'b0) begin
      failures++;
      $display("FAIL post_reset: got sum=%h co=%b ovf=%b want 78 0 0", bus.sum, bus.co, bus.ovf);
    end
    take();
  endtask

  // Test sequence.
  initial begin
    bus.in_valid  = 1'b0;
    bus.a         = 8'h00;
    bus.b         = 8'h00;
    bus.ci        = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_latency();
    test_corners();
    test_random();
    test_backpressure();
    test_busy_ignore();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
